sha256_msg_sched_ctrl: RTL
==========================

Name: sha256_msg_sched_ctrl

Overview:
- Sequences the SHA-256 message-schedule datapath for one 512-bit block.
- Accepts W[0..15] over a valid/ready input stream into a 16-entry circular window.
- Expands W[16..63] as W[t] = SIG1(W[t-2]) + W[t-7] + SIG0(W[t-15]) + W[t-16], using the sigma functions of the existing sha256 sig datapath.
- Streams all 64 words, in order, to the round engine over valid/ready.

Parameters:
- NWORDS, 64, total schedule words emitted per block. Fixed by SHA-256; not meant to be overridden.
- WIN, 16, window depth in words. Fixed at 16.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- start  input  1  begin a block. Sampled only in IDLE.
- in_valid  input  1  input word valid.
- in_ready  output  1  controller accepts in_word.
- in_word  input  32  message word W[0..15], big-endian word order.
- out_valid  output  1  out_word/out_idx valid.
- out_ready  input  1  consumer accepts the output word.
- out_word  output  32  schedule word W[t].
- out_idx  output  6  t, range 0..63.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse after the W[63] handshake.

Behaviour:
- The single clock is clk; reset is rst, synchronous, active-high. All state updates on the rising clk edge.
- Reset values: state=IDLE, in_ready=0, out_valid=0, out_word=0, out_idx=0, busy=0, done=0, load and word counters=0. Window contents are not reset.
- States and transitions:
  - IDLE: start=1 -> LOAD with load count=0.
  - LOAD: in_ready=1. On each in_valid&in_ready, win[cnt]<=in_word and cnt++. After the 16th accepted word -> CALC with t=0.
  - CALC (one cycle):
    - t<16: out_word<=win[t].
    - t>=16: compute the new word w from window slots (t+14)&15, (t+9)&15, (t+1)&15, t&15. Then out_word<=w and win[t&15]<=w.
    - Next state -> OUT.
  - OUT: out_valid=1; out_word and out_idx are held stable until out_ready. On handshake:
    - t==63 -> IDLE, done=1 for the next cycle.
    - otherwise t++ -> CALC.
- Arithmetic:
  - SIG0(x) = ror7 ^ ror18 ^ shr3.
  - SIG1(x) = ror17 ^ ror19 ^ shr10.
  - The four-term sum is modulo 2^32; carries are discarded.
- Latency and throughput:
  - First out_valid asserts 2 cycles after the 16th input handshake.
  - Steady state is 1 word per 2 cycles when out_ready is held high.
- Boundary conditions:
  - start outside IDLE is ignored.
  - in_valid outside LOAD is ignored; in_ready=0 in those states.
  - start and in_valid together in IDLE: no word is accepted that cycle.
  - out_ready low stalls indefinitely with no data loss.
  - The window write at t&15 overwrites W[t-16]. This is legal because W[t-16] has no later reader.
  - rst mid-block aborts to IDLE, no done pulse is generated, and the next block needs start plus 16 fresh words.
  - done and a new start can occur in the same cycle; the controller is already in IDLE, so the start is honoured.

Optional Feature:
- Macro: SHA256_SHARED_SIGMA_EN.
- Defined:
  - A single sigma unit (mode select SIG0/SIG1) is time-multiplexed.
  - CALC splits into CALC_A and CALC_B for t>=16:
    - CALC_A: acc<=SIG1(win[(t+14)&15]) + win[(t+9)&15].
    - CALC_B: w=acc + SIG0(win[(t+1)&15]) + win[t&15].
  - Steady state is 1 word per 3 cycles for t>=16. Words t<16 still take one CALC cycle.
  - Output values are identical to the undefined case.
- Undefined: two independent sigma instances, single-cycle CALC.

Decomposition:
- sha256_pkg holds:
  - state enum typedef.
  - localparams WIN=16, NWORDS=64.
  - rotation constants 7/18/3 and 17/19/10.
  - word_t (32-bit) typedef.
- Sub-module sha256_sig_unit: combinational, input x[31:0] and sel (0=SIG0, 1=SIG1), output y[31:0]. Instantiated twice, or once under SHA256_SHARED_SIGMA_EN.

Test Plan:
1. "abc" block: W0=0x61626380, W1..W14=0, W15=0x00000018, out_ready=1 -> out_idx 16 gives 0x61626380 and out_idx 17 gives 0x000F0000; all 64 words match the golden model; done pulses once.
2. out_ready toggling pseudo-randomly during test 1 -> identical word sequence, no drops or duplicates, out_word stable while out_valid&!out_ready.
3. Input gaps (in_valid low 3 cycles between words) and start re-asserted during LOAD -> load count unaffected by start; first out_valid exactly 2 cycles after the 16th handshake.
4. rst asserted at out_idx=30 -> next cycle busy=0, out_valid=0, no done; then a new "abc" block reproduces test 1 results.
5. All-ones block (W0..W15=0xFFFFFFFF) -> W[16..63] match the golden model, exercising 32-bit wrap of the sum.
6. With SHA256_SHARED_SIGMA_EN defined, rerun tests 1 and 5 -> same words; with out_ready=1, 3 cycles between handshakes for t>=16.

Source files
------------

// File: rtl/sha256_pkg.sv
// ============================================================================
//  Module   : sha256_pkg
//  Brief    : Shared types, constants and helpers for the SHA-256 message
//             schedule controller and its sigma datapath.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package sha256_pkg;

    localparam int unsigned WIN    = 16;
    localparam int unsigned NWORDS = 64;

    localparam int unsigned SIG0_R1 = 7;
    localparam int unsigned SIG0_R2 = 18;
    localparam int unsigned SIG0_SH = 3;
    localparam int unsigned SIG1_R1 = 17;
    localparam int unsigned SIG1_R2 = 19;
    localparam int unsigned SIG1_SH = 10;

    typedef logic [31:0] word_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_CALC   = 3'd2,
        ST_CALC_B = 3'd3,
        ST_OUT    = 3'd4
    } state_e;

    function automatic word_t ror32(input word_t x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

endpackage

`default_nettype wire

// File: rtl/sha256_sig_unit.sv
// ============================================================================
//  Module   : sha256_sig_unit
//  Brief    : Combinational SHA-256 small sigma: sel=0 gives SIG0, sel=1 SIG1.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sha256_sig_unit
    import sha256_pkg::*;
(
    input  logic [31:0] x,
    input  logic        sel,
    output logic [31:0] y
);

    logic [31:0] w_sig0;
    logic [31:0] w_sig1;

    assign w_sig0 = ror32(x, SIG0_R1) ^ ror32(x, SIG0_R2) ^ (x >> SIG0_SH);
    assign w_sig1 = ror32(x, SIG1_R1) ^ ror32(x, SIG1_R2) ^ (x >> SIG1_SH);
    assign y      = sel ? w_sig1 : w_sig0;

endmodule

`default_nettype wire

// File: rtl/sha256_msg_sched_ctrl.sv
// ============================================================================
//  Module   : sha256_msg_sched_ctrl
//  Brief    : Loads W[0..15] into a 16-word circular window, expands W[16..63]
//             and streams all 64 schedule words. Define SHA256_SHARED_SIGMA_EN
//             to time-multiplex a single sigma unit (3 cycles/word for t>=16).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sha256_msg_sched_ctrl
    import sha256_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_word,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_word,
    output logic [5:0]  out_idx,
    output logic        busy,
    output logic        done
);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [5:0]  t_q, t_d;
    word_t       out_word_q, out_word_d;
    logic        done_q, done_d;

    word_t       win_q [WIN];
    logic        w_win_we;
    logic [3:0]  w_win_waddr;
    word_t       w_win_wdata;

    logic        w_in_hs;
    logic        w_t_hi;
    logic [3:0]  w_idx_m2, w_idx_m7, w_idx_m15, w_idx_m16;
    word_t       w_new_word;

    assign w_in_hs   = in_valid & in_ready;
    assign w_t_hi    = (t_q[5:4] != 2'b00);
    // 4-bit wrap of t+offset is exactly the circular-window slot of W[t-k].
    assign w_idx_m2  = t_q[3:0] + 4'd14;
    assign w_idx_m7  = t_q[3:0] + 4'd9;
    assign w_idx_m15 = t_q[3:0] + 4'd1;
    assign w_idx_m16 = t_q[3:0];

`ifdef SHA256_SHARED_SIGMA_EN
    word_t acc_q, acc_d;
    logic  w_sig_sel;
    word_t w_sig_x;
    word_t w_sig_y;

    // CALC evaluates SIG1 into the accumulator; CALC_B reuses the unit for SIG0.
    assign w_sig_sel  = (state_q == ST_CALC);
    assign w_sig_x    = w_sig_sel ? win_q[w_idx_m2] : win_q[w_idx_m15];
    assign acc_d      = (state_q == ST_CALC) ? (w_sig_y + win_q[w_idx_m7]) : acc_q;
    assign w_new_word = acc_q + w_sig_y + win_q[w_idx_m16];

    sha256_sig_unit u_sig (
        .x   (w_sig_x),
        .sel (w_sig_sel),
        .y   (w_sig_y)
    );

    always_ff @(posedge clk) begin
        if (rst) acc_q <= '0;
        else     acc_q <= acc_d;
    end
`else
    word_t w_sig0;
    word_t w_sig1;

    assign w_new_word = w_sig1 + win_q[w_idx_m7] + w_sig0 + win_q[w_idx_m16];

    sha256_sig_unit u_sig1 (
        .x   (win_q[w_idx_m2]),
        .sel (1'b1),
        .y   (w_sig1)
    );

    sha256_sig_unit u_sig0 (
        .x   (win_q[w_idx_m15]),
        .sel (1'b0),
        .y   (w_sig0)
    );
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            t_q        <= '0;
            out_word_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            t_q        <= t_d;
            out_word_q <= out_word_d;
            done_q     <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_win_we) win_q[w_win_waddr] <= w_win_wdata;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_LOAD;
            ST_LOAD: if (w_in_hs && (cnt_q == 4'(WIN - 1))) state_d = ST_CALC;
`ifdef SHA256_SHARED_SIGMA_EN
            ST_CALC: state_d = w_t_hi ? ST_CALC_B : ST_OUT;
`else
            ST_CALC: state_d = ST_OUT;
`endif
            ST_CALC_B: state_d = ST_OUT;
            ST_OUT: begin
                if (out_ready) state_d = (t_q == 6'(NWORDS - 1)) ? ST_IDLE : ST_CALC;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cnt_d       = cnt_q;
        t_d         = t_q;
        out_word_d  = out_word_q;
        done_d      = 1'b0;
        w_win_we    = 1'b0;
        w_win_waddr = w_idx_m16;
        w_win_wdata = w_new_word;
        case (state_q)
            ST_IDLE: if (start) cnt_d = '0;
            ST_LOAD: begin
                if (w_in_hs) begin
                    w_win_we    = 1'b1;
                    w_win_waddr = cnt_q;
                    w_win_wdata = in_word;
                    cnt_d       = cnt_q + 4'd1;
                    if (cnt_q == 4'(WIN - 1)) t_d = '0;
                end
            end
            ST_CALC: begin
                if (!w_t_hi) begin
                    out_word_d = win_q[w_idx_m16];
                end else begin
`ifndef SHA256_SHARED_SIGMA_EN
                    out_word_d = w_new_word;
                    w_win_we   = 1'b1;
`endif
                end
            end
            ST_CALC_B: begin
                out_word_d = w_new_word;
                w_win_we   = 1'b1;
            end
            ST_OUT: begin
                if (out_ready) begin
                    if (t_q == 6'(NWORDS - 1)) done_d = 1'b1;
                    else                       t_d    = t_q + 6'd1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state_q)
            ST_IDLE: busy      = 1'b0;
            ST_LOAD: in_ready  = 1'b1;
            ST_OUT:  out_valid = 1'b1;
            default: ;
        endcase
    end

    assign out_word = out_word_q;
    assign out_idx  = t_q;
    assign done     = done_q;

endmodule

`default_nettype wire
